// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync pattern then payload, MSB first, one bit per clock,
// followed by a fixed idle gap so a downstream "1011" detector can lock on each header.
module seq_frame_tx #(
  parameter int                DATA_W = 8,
  parameter int                SYNC_W = 4,
  parameter logic [SYNC_W-1:0] SYNC   = 4'b1011,
  parameter int                GAP    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din_data,
  output logic              din_ready,
  output logic              dout,
  output logic              dout_en,
  output logic              busy,
  output logic              frame_done
);

  localparam int TW      = SYNC_W + DATA_W;
  localparam int MAX_SD  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int MAX_ALL = (MAX_SD > GAP) ? MAX_SD : GAP;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] SYNC_LOAD = CW'(SYNC_W - 1);
  localparam logic [CW-1:0] DATA_LOAD = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_GAP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [TW-1:0]   sh;
  logic [TW-1:0]   load_word;

  // Sync and payload share one shift register so every frame bit leaves from the same MSB.
  assign load_word = {SYNC, din_data};
  assign din_ready = (state == ST_IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sh         <= '0;
      dout       <= 1'b0;
      dout_en    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          frame_done <= 1'b0;
          if (din_valid) begin
            state   <= ST_SYNC;
            cnt     <= SYNC_LOAD;
            sh      <= load_word << 1;
            dout    <= load_word[TW-1];
            dout_en <= 1'b1;
            busy    <= 1'b1;
          end else begin
            dout    <= 1'b0;
            dout_en <= 1'b0;
            busy    <= 1'b0;
          end
        end

        ST_SYNC: begin
          dout <= sh[TW-1];
          sh   <= sh << 1;
          if (cnt == '0) begin
            state      <= ST_DATA;
            cnt        <= DATA_LOAD;
            frame_done <= 1'(DATA_W == 1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        ST_DATA: begin
          if (cnt == '0) begin
            dout       <= 1'b0;
            dout_en    <= 1'b0;
            frame_done <= 1'b0;
            sh         <= '0;
            if (GAP == 0) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_GAP;
              cnt   <= GAP_LOAD;
            end
          end else begin
            dout       <= sh[TW-1];
            sh         <= sh << 1;
            cnt        <= cnt - CW'(1);
            frame_done <= (cnt == CW'(1));
          end
        end

        ST_GAP: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: default build and GAP=0 build, checked cycle by cycle against
// a queue of expected line symbols derived from the frame format.
module tb_seq_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       v     [2];
  logic [7:0] d     [2];
  logic       ready [2];
  logic       dout  [2];
  logic       en    [2];
  logic       busy  [2];
  logic       fd    [2];

  seq_frame_tx dut (
    .clk(clk), .rst(rst), .din_valid(v[0]), .din_data(d[0]), .din_ready(ready[0]),
    .dout(dout[0]), .dout_en(en[0]), .busy(busy[0]), .frame_done(fd[0]));

  seq_frame_tx #(.GAP(0)) dut0 (
    .clk(clk), .rst(rst), .din_valid(v[1]), .din_data(d[1]), .din_ready(ready[1]),
    .dout(dout[1]), .dout_en(en[1]), .busy(busy[1]), .frame_done(fd[1]));

  typedef struct packed {logic ls; logic fd; logic en; logic b;} ent_t;

  int   compared   = 0;
  int   mismatched = 0;
  ent_t q [2][$];
  int   dut_acc [2][$];
  bit   idle_m [2];
  logic prev_ls;
  int   cyc = 0;
  bit   det_on = 0;
  logic [3:0] hist;
  int   det_count;
  logic [11:0] obs;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    compared++;
    assert (o === e) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // A frame on the line: 4 sync symbols, 8 payload symbols MSB first, then gap idle symbols.
  task automatic push_frame(input int k, input logic [7:0] data, input int gap);
    logic [3:0] sp;
    ent_t e;
    sp = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      e = '{ls: (i == 0), fd: 1'b0, en: 1'b1, b: sp[i]};
      q[k].push_back(e);
    end
    for (int i = 7; i >= 0; i--) begin
      e = '{ls: 1'b0, fd: (i == 0), en: 1'b1, b: data[i]};
      q[k].push_back(e);
    end
    for (int i = 0; i < gap; i++) q[k].push_back(ent_t'(0));
  endtask

  task automatic step();
    bit         acc [2];
    logic [7:0] dl  [2];
    logic       line_bit;
    logic       det;
    ent_t       e;
    bit         popped;
    line_bit = dout[0];
    for (int k = 0; k < 2; k++) begin
      acc[k] = !rst && v[k] && idle_m[k];
      dl[k]  = d[k];
      if (ready[k] && v[k]) dut_acc[k].push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (det_on) begin
      hist = {hist[2:0], line_bit};
      det  = (hist == 4'b1011);
      if (det) begin
        hist = 4'b0000;
        det_count++;
      end
      chk("det_pulse", det, prev_ls);
    end
    for (int k = 0; k < 2; k++) begin
      if (rst) q[k].delete();
      if (acc[k]) push_frame(k, dl[k], (k == 0) ? 1 : 0);
      popped = (q[k].size() > 0);
      e = popped ? q[k].pop_front() : ent_t'(0);
      idle_m[k] = !popped;
      if (k == 0) prev_ls = e.ls;
      chk($sformatf("dout%0d", k),  dout[k], e.b);
      chk($sformatf("en%0d", k),    en[k],   e.en);
      chk($sformatf("fd%0d", k),    fd[k],   e.fd);
      chk($sformatf("busy%0d", k),  busy[k], popped);
      chk($sformatf("ready%0d", k), ready[k], !popped && !rst);
    end
  endtask

  task automatic capture12();
    obs = '0;
    for (int i = 0; i < 12; i++) begin
      obs = {obs[10:0], dout[0]};
      step();
    end
  endtask

  initial begin
    int n0;
    rst = 1'b1;
    v[0] = 0; v[1] = 0; d[0] = 0; d[1] = 0;
    idle_m[0] = 1; idle_m[1] = 1;
    prev_ls = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready[0], 0);
    chk("rst_dout",  dout[0],  0);
    chk("rst_en",    en[0],    0);
    chk("rst_busy",  busy[0],  0);
    chk("rst_fd",    fd[0],    0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", ready[0], 1);

    // single frame A5
    v[0] = 1; d[0] = 8'hA5;
    step();
    v[0] = 0;
    capture12();
    chk("frame_A5", obs, 12'hBA5);
    repeat (2) step();

    // back-to-back 3C, C3
    dut_acc[0].delete();
    v[0] = 1; d[0] = 8'h3C;
    step();
    d[0] = 8'hC3;
    repeat (14) step();
    v[0] = 0;
    capture12();
    chk("frame_C3", obs, 12'hBC3);
    chk("b2b_period", dut_acc[0][1] - dut_acc[0][0], 14);
    repeat (3) step();

    // stability under input activity
    dut_acc[0].delete();
    v[0] = 1; d[0] = 8'h5A;
    step();
    obs = '0;
    for (int i = 0; i < 12; i++) begin
      obs = {obs[10:0], dout[0]};
      v[0] = 1'($urandom_range(0, 1));
      d[0] = 8'hFF;
      step();
    end
    v[0] = 0;
    chk("frame_5A_stable", obs, 12'hB5A);
    repeat (3) step();
    chk("stable_accepts", dut_acc[0].size(), 1);

    // reset during payload bit 3
    v[0] = 1; d[0] = 8'($urandom);
    step();
    v[0] = 0;
    repeat (7) step();
    #1 rst = 1'b1;
    #1;
    chk("midrst_dout", dout[0], 0);
    chk("midrst_en",   en[0],   0);
    chk("midrst_busy", busy[0], 0);
    step();
    rst = 1'b0;
    #1;
    chk("postrst_ready", ready[0], 1);
    v[0] = 1; d[0] = 8'h81;
    step();
    v[0] = 0;
    capture12();
    chk("frame_81", obs, 12'hB81);
    repeat (3) step();

    // GAP=0 build with valid held high
    dut_acc[1].delete();
    v[1] = 1;
    for (int i = 0; i < 45; i++) begin
      d[1] = 8'($urandom);
      step();
    end
    v[1] = 0;
    repeat (14) step();
    chk("gap0_accepts", dut_acc[1].size(), 4);
    for (int i = 1; i < dut_acc[1].size(); i++)
      chk("gap0_period", dut_acc[1][i] - dut_acc[1][i-1], 13);

    // loopback into a non-overlapping 1011 detector
    hist = '0; det_count = 0; det_on = 1;
    dut_acc[0].delete();
    v[0] = 1; d[0] = 8'h00;
    n0 = 0;
    while (dut_acc[0].size() < 10 && n0 < 200) begin
      step();
      n0++;
    end
    v[0] = 0;
    repeat (16) step();
    det_on = 0;
    chk("det_count", det_count, 10);

    // random traffic on both builds
    for (int i = 0; i < 400; i++) begin
      v[0] = ($urandom_range(0, 3) != 0);
      v[1] = ($urandom_range(0, 1) != 0);
      d[0] = 8'($urandom);
      d[1] = 8'($urandom);
      step();
    end
    v[0] = 0; v[1] = 0;
    repeat (16) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
